// File: rtl/imem_upload_ctrl_if.sv
// Upload port bundle: UART byte stream and start pulse in, memory write
// port and CPU/status controls out.
interface imem_upload_ctrl_if;
   logic        start;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        upg_rst_o;
   logic        upg_wen_o;
   logic [14:0] upg_adr_o;
   logic [31:0] upg_dat_o;
   logic        upg_done_o;
   logic        cpu_rstn_o;
   logic        err_o;

   // Controller side
   modport slave (
      input  start, rx_valid, rx_data,
      output upg_rst_o, upg_wen_o, upg_adr_o, upg_dat_o,
             upg_done_o, cpu_rstn_o, err_o
   );

   // Byte source / observer side
   modport master (
      output start, rx_valid, rx_data,
      input  upg_rst_o, upg_wen_o, upg_adr_o, upg_dat_o,
             upg_done_o, cpu_rstn_o, err_o
   );
endinterface

// File: rtl/imem_upload_ctrl.sv
// Memory upload sequencer: receives a 4-byte header (word count, bank) and
// then little-endian 32-bit words over a byte stream, writes each word to
// the selected memory bank, and keeps the CPU in reset for the whole session.
module imem_upload_ctrl #(
   parameter int TIMEOUT_CYC = 1000000,
   parameter int MAX_WORDS   = 16384
) (
   input  logic             clk,
   input  logic             rstn,
   imem_upload_ctrl_if.slave bus
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, DONE, ERR} state_t;

   state_t        state_reg;
   logic [1:0]    byte_cnt_reg;
   logic [23:0]   asm_reg;       // first three bytes of the current group, b2:b1:b0
   logic [14:0]   n_words_reg;
   logic [13:0]   word_idx_reg;
   logic          bank_reg;
   logic [TW-1:0] timer_reg;

   logic          upg_rst_reg;
   logic          upg_wen_reg;
   logic [14:0]   upg_adr_reg;
   logic [31:0]   upg_dat_reg;
   logic          upg_done_reg;
   logic          cpu_rstn_reg;
   logic          err_reg;

   logic [15:0]   hdr_n;
   logic [14:0]   idx_plus1;
   logic          timeout_hit;

   assign hdr_n       = asm_reg[15:0];
   assign idx_plus1   = {1'b0, word_idx_reg} + 15'd1;
   assign timeout_hit = (timer_reg == TW'(TIMEOUT_CYC - 1));

   assign bus.upg_rst_o  = upg_rst_reg;
   assign bus.upg_wen_o  = upg_wen_reg;
   assign bus.upg_adr_o  = upg_adr_reg;
   assign bus.upg_dat_o  = upg_dat_reg;
   assign bus.upg_done_o = upg_done_reg;
   assign bus.cpu_rstn_o = cpu_rstn_reg;
   assign bus.err_o      = err_reg;

   // Session FSM with all outputs registered alongside the state
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg    <= IDLE;
         byte_cnt_reg <= '0;
         asm_reg      <= '0;
         n_words_reg  <= '0;
         word_idx_reg <= '0;
         bank_reg     <= 1'b0;
         timer_reg    <= '0;
         upg_rst_reg  <= 1'b1;
         upg_wen_reg  <= 1'b0;
         upg_adr_reg  <= '0;
         upg_dat_reg  <= '0;
         upg_done_reg <= 1'b0;
         cpu_rstn_reg <= 1'b1;
         err_reg      <= 1'b0;
      end else begin
         upg_wen_reg <= 1'b0;
         case (state_reg)
            IDLE, DONE, ERR: begin
               if (bus.start) begin
                  state_reg    <= HDR;
                  byte_cnt_reg <= '0;
                  word_idx_reg <= '0;
                  timer_reg    <= '0;
                  err_reg      <= 1'b0;
                  upg_done_reg <= 1'b0;
                  upg_rst_reg  <= 1'b0;
                  cpu_rstn_reg <= 1'b0;
               end
            end

            HDR: begin
               if (bus.rx_valid) begin
                  timer_reg <= '0;
                  if (byte_cnt_reg == 2'd3) begin
                     byte_cnt_reg <= '0;
                     bank_reg     <= bus.rx_data[7];
                     if (hdr_n == 16'd0) begin
                        state_reg    <= DONE;
                        upg_rst_reg  <= 1'b1;
                        upg_done_reg <= 1'b1;
                        cpu_rstn_reg <= 1'b1;
                     end else if ({1'b0, hdr_n} > 17'(MAX_WORDS)) begin
                        state_reg    <= ERR;
                        upg_rst_reg  <= 1'b1;
                        err_reg      <= 1'b1;
                        upg_done_reg <= 1'b0;
                        cpu_rstn_reg <= 1'b1;
                     end else begin
                        n_words_reg <= hdr_n[14:0];
                        state_reg   <= DATA;
                     end
                  end else begin
                     asm_reg      <= {bus.rx_data, asm_reg[23:8]};
                     byte_cnt_reg <= byte_cnt_reg + 2'd1;
                  end
               end else if (timeout_hit) begin
                  state_reg    <= ERR;
                  upg_rst_reg  <= 1'b1;
                  err_reg      <= 1'b1;
                  upg_done_reg <= 1'b0;
                  cpu_rstn_reg <= 1'b1;
               end else begin
                  timer_reg <= timer_reg + TW'(1);
               end
            end

            DATA: begin
               if (bus.rx_valid) begin
                  timer_reg <= '0;
                  if (byte_cnt_reg == 2'd3) begin
                     byte_cnt_reg <= '0;
                     upg_wen_reg  <= 1'b1;
                     upg_dat_reg  <= {bus.rx_data, asm_reg};
                     upg_adr_reg  <= {bank_reg, word_idx_reg};
                     state_reg    <= WRITE;
                  end else begin
                     asm_reg      <= {bus.rx_data, asm_reg[23:8]};
                     byte_cnt_reg <= byte_cnt_reg + 2'd1;
                  end
               end else if (timeout_hit) begin
                  state_reg    <= ERR;
                  upg_rst_reg  <= 1'b1;
                  err_reg      <= 1'b1;
                  upg_done_reg <= 1'b0;
                  cpu_rstn_reg <= 1'b1;
               end else begin
                  timer_reg <= timer_reg + TW'(1);
               end
            end

            WRITE: begin
               // Strobe is high this cycle; a byte arriving now starts the next word
               word_idx_reg <= word_idx_reg + 14'd1;
               if (idx_plus1 == n_words_reg) begin
                  state_reg    <= DONE;
                  upg_rst_reg  <= 1'b1;
                  upg_done_reg <= 1'b1;
                  cpu_rstn_reg <= 1'b1;
               end else begin
                  state_reg <= DATA;
                  if (bus.rx_valid) begin
                     asm_reg      <= {bus.rx_data, asm_reg[23:8]};
                     byte_cnt_reg <= 2'd1;
                     timer_reg    <= '0;
                  end else begin
                     timer_reg <= timer_reg + TW'(1);
                  end
               end
            end

            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_upload_ctrl.sv
// Directed bench for the upload sequencer: expected writes are queued as
// bytes are sent and matched against the write strobe by a monitor.
module tb_imem_upload_ctrl;

   logic clk;
   logic rstn;

   imem_upload_ctrl_if bus ();

   imem_upload_ctrl #(.TIMEOUT_CYC(16), .MAX_WORDS(16384)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks_total  = 0;
   int checks_passed = 0;
   int wr_count      = 0;

   logic [46:0] exp_q[$];

   function automatic void check(string tag, logic [63:0] obs, logic [63:0] exp);
      checks_total++;
      assert (obs === exp) checks_passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endfunction

   // Write monitor: every strobe must match the oldest queued expectation
   always @(negedge clk) begin
      if (bus.upg_wen_o === 1'b1) begin
         logic [46:0] e;
         wr_count++;
         $display("write adr=%h dat=%h", bus.upg_adr_o, bus.upg_dat_o);
         check("write_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("write_adr", 64'(bus.upg_adr_o), 64'(e[46:32]));
            check("write_dat", 64'(bus.upg_dat_o), 64'(e[31:0]));
         end
      end
   end

   // Global time limit
   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "time limit");
   end

   task automatic send(input logic [7:0] b, input int gap);
      @(negedge clk);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      if (gap > 0) begin
         @(negedge clk);
         bus.rx_valid = 1'b0;
         repeat (gap - 1) @(negedge clk);
      end
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      send(w[7:0], gap);
      send(w[15:8], gap);
      send(w[23:16], gap);
      send(w[31:24], gap);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic begin_session(input string tag);
      pulse_start();
      check({tag, "_upg_rst_low"}, 64'(bus.upg_rst_o), 64'd0);
      check({tag, "_cpu_rstn_low"}, 64'(bus.cpu_rstn_o), 64'd0);
      check({tag, "_err_clear"}, 64'(bus.err_o), 64'd0);
      check({tag, "_done_clear"}, 64'(bus.upg_done_o), 64'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_upg_rst"}, 64'(bus.upg_rst_o), 64'd1);
      check({tag, "_wen"}, 64'(bus.upg_wen_o), 64'd0);
      check({tag, "_adr"}, 64'(bus.upg_adr_o), 64'd0);
      check({tag, "_dat"}, 64'(bus.upg_dat_o), 64'd0);
      check({tag, "_done"}, 64'(bus.upg_done_o), 64'd0);
      check({tag, "_cpu_rstn"}, 64'(bus.cpu_rstn_o), 64'd1);
      check({tag, "_err"}, 64'(bus.err_o), 64'd0);
   endtask

   task automatic check_done(input string tag, input int writes_before, input int n);
      repeat (3) @(negedge clk);
      check({tag, "_done"}, 64'(bus.upg_done_o), 64'd1);
      check({tag, "_cpu_rstn"}, 64'(bus.cpu_rstn_o), 64'd1);
      check({tag, "_upg_rst"}, 64'(bus.upg_rst_o), 64'd1);
      check({tag, "_err"}, 64'(bus.err_o), 64'd0);
      check({tag, "_nwrites"}, 64'(wr_count - writes_before), 64'(n));
      check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      int wb;
      bus.start    = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      rstn         = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rstn = 1'b1;
      repeat (2) @(negedge clk);

      // 1: bytes in IDLE do nothing
      wb = wr_count;
      send(8'h01, 1); send(8'h00, 1); send(8'h00, 1); send(8'h00, 1);
      send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 1);
      repeat (3) @(negedge clk);
      check("idle_rx_nwrites", 64'(wr_count - wb), 64'd0);
      check_reset_vals("idle_rx");

      // 2: two words, data streamed back-to-back through the WRITE cycle
      wb = wr_count;
      begin_session("t2");
      send_word(32'h0000_0002, 1);
      exp_q.push_back({15'h0000, 32'h1234_5678});
      exp_q.push_back({15'h0001, 32'hDEAD_BEEF});
      send_word(32'h1234_5678, 0);
      send_word(32'hDEAD_BEEF, 1);
      check_done("t2", wb, 2);

      // 3: bank 1 single word; a stray start mid-header is ignored
      wb = wr_count;
      begin_session("t3");
      send(8'h01, 1); send(8'h00, 1);
      pulse_start();
      send(8'h00, 1); send(8'h80, 1);
      exp_q.push_back({15'h4000, 32'h0000_0001});
      send_word(32'h0000_0001, 1);
      check_done("t3", wb, 1);
      check("t3_adr_hold", 64'(bus.upg_adr_o), 64'h4000);
      check("t3_dat_hold", 64'(bus.upg_dat_o), 64'h1);

      // 4: zero words, then an oversize count
      wb = wr_count;
      begin_session("t4a");
      send_word(32'h0000_0000, 1);
      check_done("t4a", wb, 0);
      begin_session("t4b");
      send_word(32'h0000_4001, 1);
      repeat (2) @(negedge clk);
      check("t4b_err", 64'(bus.err_o), 64'd1);
      check("t4b_done", 64'(bus.upg_done_o), 64'd0);
      check("t4b_upg_rst", 64'(bus.upg_rst_o), 64'd1);
      check("t4b_cpu_rstn", 64'(bus.cpu_rstn_o), 64'd1);

      // 4c: exactly MAX_WORDS is accepted; abandon it via the timeout
      begin_session("t4c");
      send_word(32'h0000_4000, 1);
      check("t4c_err", 64'(bus.err_o), 64'd0);
      check("t4c_upg_rst", 64'(bus.upg_rst_o), 64'd0);
      repeat (20) @(negedge clk);
      check("t4c_timeout_err", 64'(bus.err_o), 64'd1);

      // 5: timeout 16 cycles after the last byte, then a clean reload
      wb = wr_count;
      begin_session("t5");
      send_word(32'h0000_0001, 1);
      send(8'h11, 1);
      send(8'h22, 1);
      repeat (15) @(negedge clk);
      check("t5_err_before", 64'(bus.err_o), 64'd0);
      @(negedge clk);
      check("t5_err_at16", 64'(bus.err_o), 64'd1);
      check("t5_upg_rst", 64'(bus.upg_rst_o), 64'd1);
      check("t5_cpu_rstn", 64'(bus.cpu_rstn_o), 64'd1);
      check("t5_nwrites", 64'(wr_count - wb), 64'd0);
      begin_session("t5r");
      send_word(32'h0000_0001, 1);
      exp_q.push_back({15'h0000, 32'h1122_3344});
      send_word(32'h1122_3344, 1);
      check_done("t5r", wb, 1);

      // 6: reset in the middle of an 8-word load
      wb = wr_count;
      begin_session("t6");
      send_word(32'h0000_0008, 1);
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back({15'(i), 32'hA5A5_0000 + 32'(i)});
         send_word(32'hA5A5_0000 + 32'(i), 1);
      end
      send(8'h03, 1);
      send(8'h00, 1);
      rstn = 1'b0;
      #1;
      check_reset_vals("t6_rst");
      @(negedge clk);
      rstn = 1'b1;
      send(8'hA5, 1); send(8'hA5, 1);
      send_word(32'hA5A5_0004, 1);
      repeat (3) @(negedge clk);
      check("t6_nwrites", 64'(wr_count - wb), 64'd3);
      check("t6_queue_empty", 64'(exp_q.size()), 64'd0);
      check_reset_vals("t6_after");

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
